// File: rtl/adc_capture_engine_if.sv
// Purpose : bundles the ADC sample stream, capture controls and RAM write port of adc_capture_engine.
// Latency : none, wiring only.
// Backpressure: none; the RAM side always accepts a write, the ADC side is a plain strobe.
// Ports (slave = capture engine, master = whoever drives it):
//   i_data/i_valid            packed channel samples and their one-cycle strobe
//   i_start/i_abort           capture start pulse and cancel
//   i_memory_size/i_decimation capture length and keep-1-of-N factor, latched at start
//   i_threshold               channel-0 trigger level (only with ADC_CAPTURE_TRIG_EN)
//   o_wr_en/o_addr/o_data     registered RAM write port
//   o_busy/o_end              status
interface adc_capture_engine_if #(
   parameter int ZMOD_DATA_SIZE    = 14,
   parameter int SAMPLER_DATA_SIZE = 16,
   parameter int ADDR_SIZE         = 12,
   parameter int NUM_CHANNELS      = 2,
   parameter int DEC_SIZE          = 8
) ();
   logic [NUM_CHANNELS*ZMOD_DATA_SIZE-1:0]    i_data;
   logic                                      i_valid;
   logic                                      i_start;
   logic                                      i_abort;
   logic [ADDR_SIZE-1:0]                      i_memory_size;
   logic [DEC_SIZE-1:0]                       i_decimation;
`ifdef ADC_CAPTURE_TRIG_EN
   logic [ZMOD_DATA_SIZE-1:0]                 i_threshold;
`endif
   logic                                      o_wr_en;
   logic [ADDR_SIZE-1:0]                      o_addr;
   logic [NUM_CHANNELS*SAMPLER_DATA_SIZE-1:0] o_data;
   logic                                      o_busy;
   logic                                      o_end;

`ifdef ADC_CAPTURE_TRIG_EN
   modport slave (
      input  i_data, i_valid, i_start, i_abort, i_memory_size, i_decimation, i_threshold,
      output o_wr_en, o_addr, o_data, o_busy, o_end
   );
   modport master (
      output i_data, i_valid, i_start, i_abort, i_memory_size, i_decimation, i_threshold,
      input  o_wr_en, o_addr, o_data, o_busy, o_end
   );
`else
   modport slave (
      input  i_data, i_valid, i_start, i_abort, i_memory_size, i_decimation,
      output o_wr_en, o_addr, o_data, o_busy, o_end
   );
   modport master (
      output i_data, i_valid, i_start, i_abort, i_memory_size, i_decimation,
      input  o_wr_en, o_addr, o_data, o_busy, o_end
   );
`endif
endinterface

// File: rtl/adc_capture_engine.sv
// Purpose : captures NUM_CHANNELS sign-extended ADC streams into sample RAM with programmable length/decimation.
// Latency : i_valid sampled at edge k -> o_wr_en/o_addr/o_data valid during cycle k+1.
// Backpressure: none; samples arriving while not writing are dropped, i_start ignored while busy.
// Ports: i_clock, i_reset (synchronous, active high), bus (adc_capture_engine_if.slave).
// Optional feature macro ADC_CAPTURE_TRIG_EN: adds i_threshold and an ARM state that waits for a
// rising channel-0 crossing of the threshold before writing; undefined -> start goes straight to WRITE.
module adc_capture_engine #(
   parameter int ZMOD_DATA_SIZE    = 14,
   parameter int SAMPLER_DATA_SIZE = 16,
   parameter int ADDR_SIZE         = 12,
   parameter int NUM_CHANNELS      = 2,
   parameter int DEC_SIZE          = 8,
   parameter int END_HOLD          = 4
) (
   input logic                 i_clock,
   input logic                 i_reset,
   adc_capture_engine_if.slave bus
);
   // One extra counter bit so a size of 2**ADDR_SIZE is representable.
   localparam int CW  = ADDR_SIZE + 1;
   localparam int ECW = $clog2(END_HOLD + 1);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_WRITE, S_END} state_t;

   state_t                                   state, state_nxt;
   logic [CW-1:0]                            size_q;
   logic [CW-1:0]                            wr_cnt;
   logic [DEC_SIZE-1:0]                      dec_q;
   logic [DEC_SIZE-1:0]                      dec_cnt;
   logic [DEC_SIZE-1:0]                      dec_cnt_adv;
   logic [ECW-1:0]                           end_cnt;
   logic [NUM_CHANNELS*SAMPLER_DATA_SIZE-1:0] sext;
   logic                                     take;
   logic                                     last;
   logic                                     trig;
   logic                                     start_ok;

`ifdef ADC_CAPTURE_TRIG_EN
   logic signed [ZMOD_DATA_SIZE-1:0] ch0_cur;
   logic signed [ZMOD_DATA_SIZE-1:0] ch0_prev;
   logic signed [ZMOD_DATA_SIZE-1:0] thr;
   logic                             prev_vld;

   assign ch0_cur = $signed(bus.i_data[ZMOD_DATA_SIZE-1:0]);
   assign thr     = $signed(bus.i_threshold);
   // No crossing can be judged until a previous sample exists in this ARM period.
   assign trig    = (state == S_ARM) && bus.i_valid && prev_vld &&
                    (ch0_prev < thr) && (ch0_cur >= thr);
`else
   assign trig    = 1'b0;
`endif

   // Per-channel sign extension; a signed size cast replicates the top bit.
   always_comb begin
      sext = '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         sext[k*SAMPLER_DATA_SIZE +: SAMPLER_DATA_SIZE] =
            SAMPLER_DATA_SIZE'($signed(bus.i_data[k*ZMOD_DATA_SIZE +: ZMOD_DATA_SIZE]));
      end
   end

   assign last        = (wr_cnt + CW'(1)) == size_q;
   assign dec_cnt_adv = (dec_cnt == dec_q - DEC_SIZE'(1)) ? '0 : dec_cnt + DEC_SIZE'(1);
   assign start_ok    = (state == S_IDLE) && bus.i_start && !bus.i_abort;

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.i_start) begin
`ifdef ADC_CAPTURE_TRIG_EN
               state_nxt = S_ARM;
`else
               state_nxt = S_WRITE;
`endif
            end
         end
         S_ARM: begin
            // The crossing sample itself is the first one written.
            if (trig) begin
               take      = 1'b1;
               state_nxt = last ? S_END : S_WRITE;
            end
         end
         S_WRITE: begin
            if (bus.i_valid && (dec_cnt == '0)) begin
               take = 1'b1;
               if (last) state_nxt = S_END;
            end
         end
         S_END: begin
            if (end_cnt == ECW'(END_HOLD - 1)) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // Abort wins over everything and suppresses the write on its edge.
      if (bus.i_abort) begin
         state_nxt = S_IDLE;
         take      = 1'b0;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state       <= S_IDLE;
         size_q      <= '0;
         wr_cnt      <= '0;
         dec_q       <= '0;
         dec_cnt     <= '0;
         end_cnt     <= '0;
         bus.o_wr_en <= 1'b0;
         bus.o_addr  <= '0;
         bus.o_data  <= '0;
      end else begin
         state       <= state_nxt;
         bus.o_wr_en <= take;
         end_cnt     <= (state == S_END) ? end_cnt + ECW'(1) : '0;
         if (take) begin
            bus.o_addr <= wr_cnt[ADDR_SIZE-1:0];
            bus.o_data <= sext;
            wr_cnt     <= wr_cnt + CW'(1);
         end
         // Decimation phase advances on every sample seen while writing, kept or not.
         if (!bus.i_abort && (((state == S_WRITE) && bus.i_valid) || trig))
            dec_cnt <= dec_cnt_adv;
         if (start_ok) begin
            size_q  <= (bus.i_memory_size == '0) ? {1'b1, {ADDR_SIZE{1'b0}}}
                                                 : {1'b0, bus.i_memory_size};
            dec_q   <= (bus.i_decimation == '0) ? DEC_SIZE'(1) : bus.i_decimation;
            dec_cnt <= '0;
            wr_cnt  <= '0;
         end
      end
   end

`ifdef ADC_CAPTURE_TRIG_EN
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         ch0_prev <= '0;
         prev_vld <= 1'b0;
      end else if (start_ok) begin
         prev_vld <= 1'b0;
      end else if ((state == S_ARM) && bus.i_valid && !bus.i_abort) begin
         ch0_prev <= ch0_cur;
         prev_vld <= 1'b1;
      end
   end
`endif

   assign bus.o_busy = (state != S_IDLE);
   assign bus.o_end  = (state == S_END);
endmodule

// File: tb/tb_adc_capture_engine.sv
module tb_adc_capture_engine;
   localparam int ZW = 14;
   localparam int SW = 16;
   localparam int AW = 4;
   localparam int NC = 2;
   localparam int DW = 8;
   localparam int EH = 4;

   typedef struct {
      int              addr;
      logic [NC*SW-1:0] dat;
   } wr_t;

   logic i_clock = 1'b0;
   logic i_reset = 1'b1;
   int   tests   = 0;
   int   fails   = 0;
   int   end_cyc = 0;
   wr_t  wq[$];
   logic [NC*ZW-1:0] vq[$];

   always #5 i_clock = ~i_clock;

   adc_capture_engine_if #(.ZMOD_DATA_SIZE(ZW), .SAMPLER_DATA_SIZE(SW), .ADDR_SIZE(AW),
                           .NUM_CHANNELS(NC), .DEC_SIZE(DW)) bus ();

   adc_capture_engine #(.ZMOD_DATA_SIZE(ZW), .SAMPLER_DATA_SIZE(SW), .ADDR_SIZE(AW),
                        .NUM_CHANNELS(NC), .DEC_SIZE(DW), .END_HOLD(EH)) dut (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .bus     (bus)
   );

   // Observe the RAM port and END flag away from the active edge.
   always @(negedge i_clock) begin
      if (bus.o_wr_en) wq.push_back('{addr: int'(bus.o_addr), dat: bus.o_data});
      if (bus.o_end) end_cyc++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference sign extension from the numeric value of each channel.
   function automatic logic [NC*SW-1:0] sext_model(input logic [NC*ZW-1:0] raw);
      logic [NC*SW-1:0] r;
      int v;
      r = '0;
      for (int k = 0; k < NC; k++) begin
         v = int'(raw[k*ZW +: ZW]);
         if (v >= (1 << (ZW - 1))) v = v - (1 << ZW);
         r[k*SW +: SW] = SW'(v);
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic clr();
      vq.delete();
      wq.delete();
      end_cyc = 0;
   endtask

   task automatic do_start(input int size, input int dec);
      bus.i_memory_size = AW'(size);
      bus.i_decimation  = DW'(dec);
      bus.i_start       = 1'b1;
      tick();
      bus.i_start       = 1'b0;
      // Scramble the config inputs: the engine must use the latched copies.
      bus.i_memory_size = AW'($urandom);
      bus.i_decimation  = DW'($urandom);
   endtask

   task automatic drive(input logic v, input logic [NC*ZW-1:0] d);
      bus.i_valid = v;
      bus.i_data  = d;
      if (v) vq.push_back(d);
      tick();
      bus.i_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (bus.o_busy && n < 60) begin
         tick();
         n++;
      end
      chk({tag, "_idle"}, bus.o_busy, 1'b0);
   endtask

   // Expected writes: every dec-th valid sample, first size of them, at consecutive addresses.
   task automatic check_capture(input string tag, input int size_eff, input int dec_eff, input int exp_end);
      logic [NC*ZW-1:0] exp_q[$];
      for (int i = 0; i < size_eff && i * dec_eff < vq.size(); i++) exp_q.push_back(vq[i * dec_eff]);
      chk({tag, "_count"}, wq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
         chk($sformatf("%s_addr%0d", tag, i), wq[i].addr, i);
         chk($sformatf("%s_data%0d", tag, i), wq[i].dat, sext_model(exp_q[i]));
      end
      chk({tag, "_endcyc"}, end_cyc, exp_end);
   endtask

   initial begin
      int size, dec, dec_eff, need;
      bus.i_data        = '0;
      bus.i_valid       = 1'b0;
      bus.i_start       = 1'b0;
      bus.i_abort       = 1'b0;
      bus.i_memory_size = '0;
      bus.i_decimation  = '0;
`ifdef ADC_CAPTURE_TRIG_EN
      bus.i_threshold   = '0;
`endif

      // Reset state.
      repeat (3) tick();
      chk("rst_wr_en", bus.o_wr_en, 1'b0);
      chk("rst_addr",  bus.o_addr,  '0);
      chk("rst_data",  bus.o_data,  '0);
      chk("rst_busy",  bus.o_busy,  1'b0);
      chk("rst_end",   bus.o_end,   1'b0);
      i_reset = 1'b0;
      tick();
      clr();
      for (int i = 0; i < 6; i++) drive(i[0], NC*ZW'($urandom));
      chk("idle_no_wr", wq.size(), 0);
      chk("idle_busy", bus.o_busy, 1'b0);

      // size=4, dec=1, extreme channel values, with a one-cycle latency check.
      clr();
      do_start(4, 1);
      drive(1'b1, {14'h2000, 14'h1FFF});
      chk("lat_wr_en", bus.o_wr_en, 1'b1);
      chk("lat_addr",  bus.o_addr,  0);
      chk("lat_busy",  bus.o_busy,  1'b1);
      for (int i = 0; i < 5; i++) drive(1'b1, {14'h2000, 14'h1FFF});
      wait_idle("t4");
      check_capture("t4", 4, 1, EH);
      if (wq.size() > 0) chk("t4_const", wq[0].dat, 32'hE000_1FFF);
      else chk("t4_const_present", wq.size(), 1);

      // size=3, dec=3, ch0 ramp 0..8.
      clr();
      do_start(3, 3);
      for (int i = 0; i < 9; i++) drive(1'b1, {ZW'($urandom), ZW'(i)});
      wait_idle("t3");
      check_capture("t3", 3, 3, EH);

      // size=0 means full depth: 16 writes, no wrap.
      clr();
      do_start(0, 1);
      for (int i = 0; i < 20; i++) drive(1'b1, NC*ZW'($urandom));
      wait_idle("full");
      check_capture("full", 1 << AW, 1, EH);

      // Randomized captures with sparse valids, dec 0 treated as 1, start ignored mid-capture.
      for (int it = 0; it < 8; it++) begin
         clr();
         size    = $urandom_range(1, 6);
         dec     = $urandom_range(0, 4);
         dec_eff = (dec == 0) ? 1 : dec;
         need    = size * dec_eff + 2;
         do_start(size, dec);
         for (int c = 0; c < 300 && vq.size() < need; c++) begin
            bus.i_start = (c == 1);
            bus.i_memory_size = AW'($urandom);
            drive(($urandom_range(0, 9) < 6), NC*ZW'($urandom));
            bus.i_start = 1'b0;
         end
         wait_idle($sformatf("rnd%0d", it));
         check_capture($sformatf("rnd%0d", it), size, dec_eff, EH);
      end

      // Abort after two writes; abort beats start and valid on the same edge.
      clr();
      do_start(8, 1);
      drive(1'b1, NC*ZW'($urandom));
      drive(1'b1, NC*ZW'($urandom));
      bus.i_abort = 1'b1;
      bus.i_start = 1'b1;
      drive(1'b1, NC*ZW'($urandom));
      bus.i_abort = 1'b0;
      bus.i_start = 1'b0;
      chk("abort_wr_en", bus.o_wr_en, 1'b0);
      chk("abort_busy",  bus.o_busy,  1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, NC*ZW'($urandom));
      chk("abort_count", wq.size(), 2);
      chk("abort_noend", end_cyc, 0);
      clr();
      do_start(2, 1);
      drive(1'b1, NC*ZW'($urandom));
      drive(1'b1, NC*ZW'($urandom));
      wait_idle("restart");
      check_capture("restart", 2, 1, EH);

      // Reset mid-capture returns the address to 0.
      clr();
      do_start(8, 1);
      for (int i = 0; i < 3; i++) drive(1'b1, NC*ZW'($urandom));
      i_reset = 1'b1;
      tick();
      chk("midrst_addr",  bus.o_addr,  0);
      chk("midrst_wr_en", bus.o_wr_en, 1'b0);
      chk("midrst_busy",  bus.o_busy,  1'b0);
      i_reset = 1'b0;
      tick();

`ifdef ADC_CAPTURE_TRIG_EN
      // Rising crossing of 100 on channel 0: 120 is the first sample written.
      clr();
      bus.i_threshold = ZW'(100);
      do_start(2, 1);
      drive(1'b1, {14'h0, 14'd50});
      drive(1'b1, {14'h0, 14'd90});
      drive(1'b1, {14'h0, 14'd120});
      bus.i_start = 1'b1;
      drive(1'b1, {14'h0, 14'd130});
      bus.i_start = 1'b0;
      drive(1'b1, {14'h0, 14'd140});
      wait_idle("trig");
      vq.delete(0);
      vq.delete(0);
      check_capture("trig", 2, 1, EH);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
